// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the five-stage pipeline hazard controller:
//   - hz_state_e   : control FSM state encoding (RUN, LDSTALL, MEMWAIT, FLUSH, HALT)
//   - FWD_*        : operand forward-select codes driven on fwd_a / fwd_b
//   - STG_*        : bit positions of each stage inside stage_en / stage_rst
//   - stage_bit()  : one-hot mask for a single stage index
// No ports (package). Optional feature macro used by the top: DEBUG_STEP_EN.
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_LDSTALL = 3'd1,
    ST_MEMWAIT = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_HALT    = 3'd4
  } hz_state_e;

  localparam logic [1:0] FWD_NO      = 2'd0;
  localparam logic [1:0] FWD_ALU_EXE = 2'd1;
  localparam logic [1:0] FWD_ALU_MEM = 2'd2;
  localparam logic [1:0] FWD_MEM     = 2'd3;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;
  localparam int STG_NUM = 5;

  localparam logic [STG_NUM-1:0] STAGE_ALL  = 5'b11111;
  localparam logic [STG_NUM-1:0] STAGE_NONE = 5'b00000;

  // One-hot mask selecting a single pipeline stage.
  function automatic logic [STG_NUM-1:0] stage_bit(input int idx);
    stage_bit = 5'b00001 << idx;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_cmp.sv
// -----------------------------------------------------------------------------
// hazard_fwd_cmp
// Combinational dependency compare for one ID source operand against the EXE
// and MEM destination registers. Register 0 never matches; EXE wins over MEM.
// Ports:
//   src, src_used            : ID source register address and its read flag
//   exe_wa/exe_wen/exe_is_load : EXE destination, write enable, load flag
//   mem_wa/mem_wen/mem_is_load : MEM destination, write enable, load flag
//   fwd_sel (out 2)          : FWD_NO / FWD_ALU_EXE / FWD_ALU_MEM / FWD_MEM
//   exe_load_hit (out 1)     : EXE holds a load writing this source (read flag
//                              not applied; the top qualifies it)
// -----------------------------------------------------------------------------
module hazard_fwd_cmp
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  logic [REG_AW-1:0] exe_wa,
  input  logic              exe_wen,
  input  logic              exe_is_load,
  input  logic [REG_AW-1:0] mem_wa,
  input  logic              mem_wen,
  input  logic              mem_is_load,
  output logic [1:0]        fwd_sel,
  output logic              exe_load_hit
);

  logic src_nz_s;
  logic exe_match_s;
  logic mem_match_s;

  assign src_nz_s     = (src != {REG_AW{1'b0}});
  assign exe_match_s  = src_nz_s && exe_wen && (exe_wa == src);
  assign mem_match_s  = src_nz_s && mem_wen && (mem_wa == src);
  // A load still in EXE has no data yet; it can only be forwarded from MEM.
  assign exe_load_hit = exe_match_s && exe_is_load;

  // Forward select: EXE ALU result first, then MEM (ALU result or load data).
  always_comb begin
    fwd_sel = FWD_NO;
    if (exe_match_s && src_used && !exe_is_load) begin
      fwd_sel = FWD_ALU_EXE;
    end else if (mem_match_s) begin
      if (mem_is_load) begin
        fwd_sel = FWD_MEM;
      end else begin
        fwd_sel = FWD_ALU_MEM;
      end
    end else begin
      fwd_sel = FWD_NO;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard / forwarding controller for a five-stage (IF ID EXE MEM WB) pipeline.
// Forwarding is combinational; stalls, flushes and memory waits are sequenced
// by a small FSM whose state alone decodes stage_en / stage_rst.
// Optional feature: define DEBUG_STEP_EN to add the HALT state with
// single-step support (adds ports debug_en, debug_step).
// Ports:
//   clk, rst (sync, active-high)
//   id_rs, id_rt, id_rs_used, id_rt_used, id_is_store : ID operand info
//   exe_wa, exe_wen, exe_is_load, mem_wa, mem_wen, mem_is_load : producers
//   branch_taken          : ID branch/jump resolved taken
//   dmem_req, dmem_ready  : MEM stage access outstanding / completed
//   debug_en, debug_step  : halt enable / step request (DEBUG_STEP_EN only)
//   fwd_a, fwd_b, fwd_m   : forward selects
//   stage_en, stage_rst   : per-stage enable / reset (bit 0 = IF)
//   state                 : current FSM state
//   stall_cnt             : saturating count of non-RUN cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_store,
  input  logic [REG_AW-1:0] exe_wa,
  input  logic [REG_AW-1:0] mem_wa,
  input  logic              exe_wen,
  input  logic              mem_wen,
  input  logic              exe_is_load,
  input  logic              mem_is_load,
  input  logic              branch_taken,
  input  logic              dmem_req,
  input  logic              dmem_ready,
`ifdef DEBUG_STEP_EN
  input  logic              debug_en,
  input  logic              debug_step,
`endif
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_m,
  output logic [4:0]        stage_en,
  output logic [4:0]        stage_rst,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [2:0]       BR_LOAD = 3'(BR_PENALTY);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  hz_state_e        state_r;
  hz_state_e        state_nx_s;
  logic [2:0]       flush_cnt_r;
  logic [2:0]       flush_dec_s;
  logic             flush_load_s;
  logic             flush_pend_s;
  logic [CNT_W-1:0] stall_cnt_r;

  logic [1:0]       rs_sel_s;
  logic [1:0]       rt_sel_s;
  logic             rs_load_hit_s;
  logic             rt_load_hit_s;
  logic             load_use_s;
  logic             mem_wait_s;
  logic             halt_req_s;
  logic             step_edge_s;

  hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp_rs (
    .src          (id_rs),
    .src_used     (id_rs_used),
    .exe_wa       (exe_wa),
    .exe_wen      (exe_wen),
    .exe_is_load  (exe_is_load),
    .mem_wa       (mem_wa),
    .mem_wen      (mem_wen),
    .mem_is_load  (mem_is_load),
    .fwd_sel      (rs_sel_s),
    .exe_load_hit (rs_load_hit_s)
  );

  hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp_rt (
    .src          (id_rt),
    .src_used     (id_rt_used),
    .exe_wa       (exe_wa),
    .exe_wen      (exe_wen),
    .exe_is_load  (exe_is_load),
    .mem_wa       (mem_wa),
    .mem_wen      (mem_wen),
    .mem_is_load  (mem_is_load),
    .fwd_sel      (rt_sel_s),
    .exe_load_hit (rt_load_hit_s)
  );

  // A store's rt is only needed at MEM, where fwd_m supplies it, so it never stalls.
  assign load_use_s = (rs_load_hit_s && id_rs_used) ||
                      (rt_load_hit_s && id_rt_used && !id_is_store);
  assign mem_wait_s = dmem_req && !dmem_ready;

`ifdef DEBUG_STEP_EN
  logic step_prev_r;

  // Previous debug_step value for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_prev_r <= 1'b0;
    end else begin
      step_prev_r <= debug_step;
    end
  end

  assign halt_req_s  = debug_en;
  assign step_edge_s = debug_step && !step_prev_r;
`else
  assign halt_req_s  = 1'b0;
  assign step_edge_s = 1'b0;
`endif

  // Flush down-counter after this cycle: it only counts while FLUSH is current,
  // so a preempting MEMWAIT/LDSTALL leaves the remaining penalty intact.
  always_comb begin
    flush_dec_s = flush_cnt_r;
    if ((state_r == ST_FLUSH) && (flush_cnt_r != 3'd0)) begin
      flush_dec_s = flush_cnt_r - 3'd1;
    end else begin
      flush_dec_s = flush_cnt_r;
    end
  end

  assign flush_pend_s = (flush_dec_s != 3'd0);

  // Next-state selection: HALT > MEMWAIT > LDSTALL > FLUSH > RUN.
  always_comb begin
    state_nx_s   = ST_RUN;
    flush_load_s = 1'b0;
    case (state_r)
      ST_HALT: begin
        if (halt_req_s) begin
          state_nx_s = ST_HALT;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_RUN, ST_LDSTALL, ST_MEMWAIT, ST_FLUSH: begin
        if (halt_req_s) begin
          state_nx_s = ST_HALT;
        end else if (mem_wait_s) begin
          state_nx_s = ST_MEMWAIT;
        end else if (load_use_s && (state_r != ST_LDSTALL)) begin
          // The stall bubble clears the hazard, so never stall twice in a row.
          state_nx_s = ST_LDSTALL;
        end else if (branch_taken) begin
          state_nx_s   = ST_FLUSH;
          flush_load_s = 1'b1;
        end else if (flush_pend_s) begin
          state_nx_s = ST_FLUSH;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_RUN;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Flush penalty counter: reloaded by a taken branch, otherwise counts down in FLUSH.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_r <= 3'd0;
    end else if (flush_load_s) begin
      flush_cnt_r <= BR_LOAD;
    end else begin
      flush_cnt_r <= flush_dec_s;
    end
  end

  // Saturating count of cycles spent outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r != ST_RUN) && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Stage control decode from the current state; reset forces every stage into reset.
  always_comb begin
    stage_en  = STAGE_NONE;
    stage_rst = STAGE_NONE;
    if (rst) begin
      stage_en  = STAGE_ALL;
      stage_rst = STAGE_ALL;
    end else begin
      case (state_r)
        ST_RUN: begin
          stage_en  = STAGE_ALL;
          stage_rst = STAGE_NONE;
        end
        ST_LDSTALL: begin
          // Hold IF/ID, inject a bubble into EXE, let the load move on.
          stage_en  = STAGE_ALL & ~(stage_bit(STG_IF) | stage_bit(STG_ID));
          stage_rst = stage_bit(STG_EXE);
        end
        ST_MEMWAIT: begin
          stage_en  = STAGE_NONE;
          stage_rst = STAGE_NONE;
        end
        ST_FLUSH: begin
          stage_en  = STAGE_ALL;
          stage_rst = stage_bit(STG_ID);
        end
        ST_HALT: begin
          if (step_edge_s) begin
            stage_en = STAGE_ALL;
          end else begin
            stage_en = STAGE_NONE;
          end
          stage_rst = STAGE_NONE;
        end
        default: begin
          stage_en  = STAGE_NONE;
          stage_rst = STAGE_NONE;
        end
      endcase
    end
  end

  // Forward selects are live whenever the controller is out of reset.
  always_comb begin
    fwd_a = FWD_NO;
    fwd_b = FWD_NO;
    fwd_m = 1'b0;
    if (rst) begin
      fwd_a = FWD_NO;
      fwd_b = FWD_NO;
      fwd_m = 1'b0;
    end else begin
      fwd_a = rs_sel_s;
      fwd_b = rt_sel_s;
      fwd_m = rt_load_hit_s && id_is_store;
    end
  end

  assign state     = state_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, exe_wa, mem_wa;
  logic        id_rs_used, id_rt_used, id_is_store;
  logic        exe_wen, mem_wen, exe_is_load, mem_is_load;
  logic        branch_taken, dmem_req, dmem_ready;
`ifdef DEBUG_STEP_EN
  logic        debug_en, debug_step;
`endif
  logic [1:0]  fwd_a, fwd_b;
  logic        fwd_m;
  logic [4:0]  stage_en, stage_rst;
  logic [2:0]  state;
  logic [15:0] stall_cnt;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic        s_fwd_m;
  logic [4:0]  s_stage_en, s_stage_rst;
  logic [2:0]  s_state;
  logic [3:0]  s_stall_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  pipeline_hazard_ctrl #(.REG_AW(5), .BR_PENALTY(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_is_store(id_is_store), .exe_wa(exe_wa), .mem_wa(mem_wa),
    .exe_wen(exe_wen), .mem_wen(mem_wen), .exe_is_load(exe_is_load), .mem_is_load(mem_is_load),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
`ifdef DEBUG_STEP_EN
    .debug_en(debug_en), .debug_step(debug_step),
`endif
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_m(fwd_m), .stage_en(stage_en),
    .stage_rst(stage_rst), .state(state), .stall_cnt(stall_cnt)
  );

  // Small-counter instance sharing all inputs, used for the saturation case.
  pipeline_hazard_ctrl #(.REG_AW(5), .BR_PENALTY(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_is_store(id_is_store), .exe_wa(exe_wa), .mem_wa(mem_wa),
    .exe_wen(exe_wen), .mem_wen(mem_wen), .exe_is_load(exe_is_load), .mem_is_load(mem_is_load),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
`ifdef DEBUG_STEP_EN
    .debug_en(debug_en), .debug_step(debug_step),
`endif
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_m(s_fwd_m), .stage_en(s_stage_en),
    .stage_rst(s_stage_rst), .state(s_state), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0; id_is_store = 1'b0;
    exe_wa = 5'd0; mem_wa = 5'd0; exe_wen = 1'b0; mem_wen = 1'b0;
    exe_is_load = 1'b0; mem_is_load = 1'b0;
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
`ifdef DEBUG_STEP_EN
    debug_en = 1'b0; debug_step = 1'b0;
`endif
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    exe_wen = 1'b1; exe_wa = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1;
    tick(); tick();
    vec_cnt++; if (state !== 3'd0) begin err_cnt++; $display("FAIL reset_state got %0d exp 0", state); end
    vec_cnt++; if (stall_cnt !== 16'd0) begin err_cnt++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    vec_cnt++; if (stage_en !== 5'b11111) begin err_cnt++; $display("FAIL reset_stage_en got %b exp 11111", stage_en); end
    vec_cnt++; if (stage_rst !== 5'b11111) begin err_cnt++; $display("FAIL reset_stage_rst got %b exp 11111", stage_rst); end
    vec_cnt++; if (fwd_a !== 2'd0) begin err_cnt++; $display("FAIL reset_fwd_a got %0d exp 0", fwd_a); end
    idle();
    rst = 1'b0;
    tick();
    vec_cnt++; if (stage_en !== 5'b11111 || stage_rst !== 5'b00000) begin
      err_cnt++; $display("FAIL run_stage got en=%b rst=%b exp 11111/00000", stage_en, stage_rst); end
  endtask

  task automatic test_forward();
    // EXE ALU r5 -> rs
    idle(); exe_wen = 1'b1; exe_wa = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1; #1;
    vec_cnt++; if (fwd_a !== 2'd1 || fwd_b !== 2'd0) begin err_cnt++; $display("FAIL fwd_exe_alu got a=%0d b=%0d exp 1/0", fwd_a, fwd_b); end
    tick();
    vec_cnt++; if (state !== 3'd0) begin err_cnt++; $display("FAIL fwd_exe_state got %0d exp 0", state); end
    // MEM ALU r3 -> rt
    idle(); mem_wen = 1'b1; mem_wa = 5'd3; id_rt = 5'd3; id_rt_used = 1'b1; #1;
    vec_cnt++; if (fwd_b !== 2'd2 || fwd_a !== 2'd0) begin err_cnt++; $display("FAIL fwd_mem_alu got a=%0d b=%0d exp 0/2", fwd_a, fwd_b); end
    // MEM load r3 -> rt
    mem_is_load = 1'b1; #1;
    vec_cnt++; if (fwd_b !== 2'd3) begin err_cnt++; $display("FAIL fwd_mem_load got %0d exp 3", fwd_b); end
    tick();
    // EXE beats MEM on r9
    idle(); exe_wen = 1'b1; exe_wa = 5'd9; mem_wen = 1'b1; mem_wa = 5'd9; mem_is_load = 1'b1;
    id_rs = 5'd9; id_rs_used = 1'b1; #1;
    vec_cnt++; if (fwd_a !== 2'd1) begin err_cnt++; $display("FAIL fwd_priority got %0d exp 1", fwd_a); end
    tick();
    // r0 never matches
    idle(); exe_wen = 1'b1; mem_wen = 1'b1; id_rs_used = 1'b1; id_rt_used = 1'b1; #1;
    vec_cnt++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin err_cnt++; $display("FAIL fwd_r0 got a=%0d b=%0d exp 0/0", fwd_a, fwd_b); end
    tick();
    vec_cnt++; if (stall_cnt !== 16'd0) begin err_cnt++; $display("FAIL fwd_no_stall got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_ldstall();
    idle(); exe_wen = 1'b1; exe_is_load = 1'b1; exe_wa = 5'd7;
    id_rt = 5'd7; id_rt_used = 1'b1; id_rs = 5'd2; id_rs_used = 1'b1; #1;
    vec_cnt++; if (state !== 3'd0 || fwd_m !== 1'b0) begin err_cnt++; $display("FAIL lds_pre got st=%0d m=%0d exp 0/0", state, fwd_m); end
    tick();
    vec_cnt++; if (state !== 3'd1) begin err_cnt++; $display("FAIL lds_state got %0d exp 1", state); end
    vec_cnt++; if (stage_en !== 5'b11100 || stage_rst !== 5'b00100) begin
      err_cnt++; $display("FAIL lds_stage got en=%b rst=%b exp 11100/00100", stage_en, stage_rst); end
    // pipeline advances: load now in MEM, bubble in EXE
    exe_wen = 1'b0; exe_is_load = 1'b0; exe_wa = 5'd0;
    mem_wen = 1'b1; mem_is_load = 1'b1; mem_wa = 5'd7;
    tick();
    vec_cnt++; if (state !== 3'd0 || stage_en !== 5'b11111) begin
      err_cnt++; $display("FAIL lds_exit got st=%0d en=%b exp 0/11111", state, stage_en); end
    vec_cnt++; if (fwd_b !== 2'd3) begin err_cnt++; $display("FAIL lds_fwd_b got %0d exp 3", fwd_b); end
    vec_cnt++; if (stall_cnt !== 16'd1) begin err_cnt++; $display("FAIL lds_cnt got %0d exp 1", stall_cnt); end
  endtask

  task automatic test_store_fwd();
    idle(); exe_wen = 1'b1; exe_is_load = 1'b1; exe_wa = 5'd7;
    id_is_store = 1'b1; id_rt = 5'd7; id_rt_used = 1'b1; id_rs = 5'd1; id_rs_used = 1'b1; #1;
    vec_cnt++; if (fwd_m !== 1'b1) begin err_cnt++; $display("FAIL store_fwd_m got %0d exp 1", fwd_m); end
    tick();
    vec_cnt++; if (state !== 3'd0 || stall_cnt !== 16'd1) begin
      err_cnt++; $display("FAIL store_nostall got st=%0d cnt=%0d exp 0/1", state, stall_cnt); end
    idle();
  endtask

  task automatic test_flush();
    idle(); branch_taken = 1'b1; tick(); branch_taken = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      vec_cnt++; if (state !== 3'd3 || stage_rst !== 5'b00010) begin
        err_cnt++; $display("FAIL flush_c%0d got st=%0d rst=%b exp 3/00010", i, state, stage_rst); end
      tick();
    end
    vec_cnt++; if (state !== 3'd0 || stage_rst !== 5'b00000) begin
      err_cnt++; $display("FAIL flush_end got st=%0d rst=%b exp 0/00000", state, stage_rst); end
    // second taken branch in flush cycle 2 extends to 5 cycles
    branch_taken = 1'b1; tick(); branch_taken = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      vec_cnt++; if (state !== 3'd3 || stage_rst[1] !== 1'b1) begin
        err_cnt++; $display("FAIL flush2_c%0d got st=%0d rst=%b exp 3/00010", i, state, stage_rst); end
      branch_taken = (i == 2);
      tick();
      branch_taken = 1'b0;
    end
    vec_cnt++; if (state !== 3'd0 || stall_cnt !== 16'd9) begin
      err_cnt++; $display("FAIL flush2_end got st=%0d cnt=%0d exp 0/9", state, stall_cnt); end
  endtask

  task automatic test_memwait_flush();
    idle(); branch_taken = 1'b1; tick(); branch_taken = 1'b0;
    vec_cnt++; if (state !== 3'd3) begin err_cnt++; $display("FAIL mwf_flush1 got %0d exp 3", state); end
    dmem_req = 1'b1; dmem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (state !== 3'd2 || stage_en !== 5'b00000 || stage_rst !== 5'b00000) begin
        err_cnt++; $display("FAIL mwf_wait%0d got st=%0d en=%b rst=%b exp 2/00000/00000", i, state, stage_en, stage_rst); end
      dmem_ready = (i == 3);
      tick();
    end
    dmem_req = 1'b0; dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vec_cnt++; if (state !== 3'd3 || stage_rst !== 5'b00010) begin
        err_cnt++; $display("FAIL mwf_resume%0d got st=%0d rst=%b exp 3/00010", i, state, stage_rst); end
      tick();
    end
    vec_cnt++; if (state !== 3'd0 || stall_cnt !== 16'd16) begin
      err_cnt++; $display("FAIL mwf_end got st=%0d cnt=%0d exp 0/16", state, stall_cnt); end
  endtask

  task automatic test_saturate_and_rst();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    vec_cnt++; if (s_stall_cnt !== 4'd0) begin err_cnt++; $display("FAIL sat_rst got %0d exp 0", s_stall_cnt); end
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    vec_cnt++; if (s_stall_cnt !== 4'd15) begin err_cnt++; $display("FAIL sat_cnt4 got %0d exp 15", s_stall_cnt); end
    vec_cnt++; if (stall_cnt !== 16'd20) begin err_cnt++; $display("FAIL sat_cnt16 got %0d exp 20", stall_cnt); end
    vec_cnt++; if (state !== 3'd2) begin err_cnt++; $display("FAIL sat_state got %0d exp 2", state); end
    rst = 1'b1; tick();
    vec_cnt++; if (state !== 3'd0 || stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin
      err_cnt++; $display("FAIL rst_memwait got st=%0d cnt=%0d cnt4=%0d exp 0/0/0", state, stall_cnt, s_stall_cnt); end
    rst = 1'b0; dmem_req = 1'b0; tick();
    vec_cnt++; if (state !== 3'd0 || stage_en !== 5'b11111 || stall_cnt !== 16'd0) begin
      err_cnt++; $display("FAIL post_rst got st=%0d en=%b cnt=%0d exp 0/11111/0", state, stage_en, stall_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_forward();
    test_ldstall();
    test_store_fwd();
    test_flush();
    test_memwait_flush();
    test_saturate_and_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
